// File: rtl/vmul_result_assembler.sv
// ---------------------------------------------------------------------------
// vmul_result_assembler
//
// Output stage of the 8-lane 8x8 unsigned multiplier array. It combines the
// eight 16-bit unsigned partial products into one registered 64-bit widening
// signed result:
//   sew=00 : four 16-bit products, each sign-corrected on its own
//   sew=01 : two 32-bit products built from four partials each
//   sew=10 : one 64-bit product accumulated over two beats (count_0 = 0, 1)
//   sew=11 : reserved, the beat is dropped
//
// Optional feature macro: SEQ_ERR_EN
//   When it is defined, the seq_err port and beat-protocol violation
//   detection are present. The FSM recovery behaviour is the same whether or
//   not the macro is defined.
//
// Ports
//   clk                   rising-edge clock
//   reset                 asynchronous, active-low reset
//   in_valid              partial-product beat present this cycle
//   sew[1:0]              element width
//   count_0               32-bit beat index (0 = first beat, 1 = second beat)
//   p1..p8[15:0]          unsigned partial products from lanes 1..8
//   sign_A0..sign_A3      MSB of operand A byte 0..3
//   sign_B0..sign_B3      MSB of operand B byte 0..3
//   seq_err               one-cycle violation pulse (SEQ_ERR_EN only)
//   result[63:0]          widening signed product(s), held between updates
//   out_valid             one-cycle pulse when result updates
//   acc_pending           first 32-bit beat stored, second beat awaited
// ---------------------------------------------------------------------------
module vmul_result_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [1:0]  sew,
   input  logic        count_0,
   input  logic [15:0] p1,
   input  logic [15:0] p2,
   input  logic [15:0] p3,
   input  logic [15:0] p4,
   input  logic [15:0] p5,
   input  logic [15:0] p6,
   input  logic [15:0] p7,
   input  logic [15:0] p8,
   input  logic        sign_A0,
   input  logic        sign_A1,
   input  logic        sign_A2,
   input  logic        sign_A3,
   input  logic        sign_B0,
   input  logic        sign_B1,
   input  logic        sign_B2,
   input  logic        sign_B3,
`ifdef SEQ_ERR_EN
   output logic        seq_err,
`endif
   output logic [63:0] result,
   output logic        out_valid,
   output logic        acc_pending
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   // Two's-complement negation helpers; negating zero naturally gives zero.
   function automatic logic [15:0] neg16(input logic [15:0] v, input logic n);
      return n ? (16'd0 - v) : v;
   endfunction

   function automatic logic [31:0] neg32(input logic [31:0] v, input logic n);
      return n ? (32'd0 - v) : v;
   endfunction

   function automatic logic [63:0] neg64(input logic [63:0] v, input logic n);
      return n ? (64'd0 - v) : v;
   endfunction

   state_t        state_r;
   state_t        state_next_s;
   logic [63:0]   result_r;
   logic          out_valid_r;
   logic [47:0]   acc_sum_r;
   logic          acc_neg_r;

   logic [63:0]   res8_s;
   logic [31:0]   elem0_s;
   logic [31:0]   elem1_s;
   logic [63:0]   res16_s;
   logic [47:0]   beat_sum_s;
   logic [63:0]   acc_total_s;
   logic [63:0]   res32_s;
   logic [63:0]   next_result_s;
   logic          produce_s;
   logic          load_acc_s;

   // 8-bit elements: each lane is its own product, sign-corrected per byte pair.
   assign res8_s = {neg16(p4, sign_A3 ^ sign_B3),
                    neg16(p3, sign_A2 ^ sign_B2),
                    neg16(p2, sign_A1 ^ sign_B1),
                    neg16(p1, sign_A0 ^ sign_B0)};

   // 16-bit elements: the two cross terms both sit at byte offset 1.
   assign elem0_s = {16'd0, p1} + ({16'd0, p2} << 5'd8) +
                    ({16'd0, p3} << 5'd8) + ({16'd0, p4} << 5'd16);
   assign elem1_s = {16'd0, p5} + ({16'd0, p6} << 5'd8) +
                    ({16'd0, p7} << 5'd8) + ({16'd0, p8} << 5'd16);
   assign res16_s = {neg32(elem1_s, sign_A3 ^ sign_B3),
                     neg32(elem0_s, sign_A1 ^ sign_B1)};

   // 32-bit beat: lanes 1..4 multiply B(2k), lanes 5..8 multiply B(2k+1),
   // so the upper group is one byte further up.
   assign beat_sum_s = {32'd0, p1}              + ({32'd0, p2} << 6'd8)  +
                       ({32'd0, p3} << 6'd16)   + ({32'd0, p4} << 6'd24) +
                       ({32'd0, p5} << 6'd8)    + ({32'd0, p6} << 6'd16) +
                       ({32'd0, p7} << 6'd24)   + ({32'd0, p8} << 6'd32);

   // Second beat covers B2/B3, i.e. two bytes above the first beat.
   assign acc_total_s = {16'd0, acc_sum_r} + ({16'd0, beat_sum_s} << 7'd16);
   assign res32_s     = neg64(acc_total_s, acc_neg_r);

   // Beat protocol: next state, result selection and accumulator load.
   always_comb begin
      state_next_s  = state_r;
      next_result_s = result_r;
      produce_s     = 1'b0;
      load_acc_s    = 1'b0;
      if (in_valid) begin
         case (sew)
            2'b00: begin
               next_result_s = res8_s;
               produce_s     = 1'b1;
               state_next_s  = IDLE;
            end
            2'b01: begin
               next_result_s = res16_s;
               produce_s     = 1'b1;
               state_next_s  = IDLE;
            end
            2'b10: begin
               if (!count_0) begin
                  // A first beat always (re)starts accumulation.
                  load_acc_s   = 1'b1;
                  state_next_s = ACC;
               end else if (state_r == ACC) begin
                  next_result_s = res32_s;
                  produce_s     = 1'b1;
                  state_next_s  = IDLE;
               end else begin
                  // Orphan second beat: dropped.
                  state_next_s = IDLE;
               end
            end
            default: begin
               // Reserved width: dropped, any stored beat is abandoned.
               state_next_s = IDLE;
            end
         endcase
      end else begin
         state_next_s = state_r;
      end
   end

   // State, result and accumulator registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         result_r    <= 64'd0;
         out_valid_r <= 1'b0;
         acc_sum_r   <= 48'd0;
         acc_neg_r   <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         result_r    <= next_result_s;
         out_valid_r <= produce_s;
         if (load_acc_s) begin
            acc_sum_r <= beat_sum_s;
            acc_neg_r <= sign_A3 ^ sign_B3;
         end else begin
            acc_sum_r <= acc_sum_r;
            acc_neg_r <= acc_neg_r;
         end
      end
   end

   assign result      = result_r;
   assign out_valid   = out_valid_r;
   assign acc_pending = (state_r == ACC);

`ifdef SEQ_ERR_EN
   logic violation_s;
   logic seq_err_r;

   // Violation: orphan second beat in IDLE, or anything but a second 32-bit
   // beat while a first beat is waiting.
   always_comb begin
      violation_s = 1'b0;
      if (in_valid) begin
         if (state_r == ACC) begin
            violation_s = !((sew == 2'b10) && count_0);
         end else begin
            violation_s = (sew == 2'b10) && count_0;
         end
      end else begin
         violation_s = 1'b0;
      end
   end

   // Register the violation flag as a one-cycle pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seq_err_r <= 1'b0;
      end else begin
         seq_err_r <= violation_s;
      end
   end

   assign seq_err = seq_err_r;
`endif

endmodule

// File: tb/tb_vmul_result_assembler.sv
module tb_vmul_result_assembler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [1:0]  sew = 2'b00;
   logic        count_0 = 1'b0;
   logic [15:0] p [8];
   logic [3:0]  sa = 4'd0;
   logic [3:0]  sb = 4'd0;
   logic [63:0] result;
   logic        out_valid;
   logic        acc_pending;
`ifdef SEQ_ERR_EN
   logic        seq_err;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   bit              m_pend   = 1'b0;
   longint unsigned m_s0     = 64'd0;
   bit              m_neg    = 1'b0;
   longint unsigned m_result = 64'd0;
   bit              exp_ov   = 1'b0;
   bit              exp_err  = 1'b0;

   always #5 clk = ~clk;

   vmul_result_assembler dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .sew(sew), .count_0(count_0),
      .p1(p[0]), .p2(p[1]), .p3(p[2]), .p4(p[3]),
      .p5(p[4]), .p6(p[5]), .p7(p[6]), .p8(p[7]),
      .sign_A0(sa[0]), .sign_A1(sa[1]), .sign_A2(sa[2]), .sign_A3(sa[3]),
      .sign_B0(sb[0]), .sign_B1(sb[1]), .sign_B2(sb[2]), .sign_B3(sb[3]),
`ifdef SEQ_ERR_EN
      .seq_err(seq_err),
`endif
      .result(result), .out_valid(out_valid), .acc_pending(acc_pending)
   );

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic longint unsigned model8();
      longint unsigned r = 0;
      longint unsigned v;
      longint unsigned w = 1;
      for (int i = 0; i < 4; i++) begin
         v = p[i];
         if (sa[i] != sb[i]) v = (65536 - v) % 65536;
         r = r + v * w;
         w = w * 65536;
      end
      return r;
   endfunction

   function automatic longint unsigned model16();
      longint unsigned m32 = 64'h1_0000_0000;
      longint unsigned e0, e1;
      e0 = (p[0] + 256 * p[1] + 256 * p[2] + 65536 * longint'(p[3])) % m32;
      e1 = (p[4] + 256 * p[5] + 256 * p[6] + 65536 * longint'(p[7])) % m32;
      if (sa[1] != sb[1]) e0 = (m32 - e0) % m32;
      if (sa[3] != sb[3]) e1 = (m32 - e1) % m32;
      return e0 + e1 * m32;
   endfunction

   function automatic longint unsigned model_beat();
      longint unsigned s = 0;
      longint unsigned w = 1;
      for (int i = 0; i < 4; i++) begin
         s = s + longint'(p[i]) * w + longint'(p[i+4]) * w * 256;
         w = w * 256;
      end
      return s % 64'h1_0000_0000_0000;
   endfunction

   // Apply one cycle of stimulus, predict, clock, compare.
   task automatic step(input bit v, input logic [1:0] s, input bit c);
      longint unsigned tot;
      in_valid = v; sew = s; count_0 = c;
      exp_ov = 1'b0; exp_err = 1'b0;
      if (v) begin
         if (s == 2'b00 || s == 2'b01) begin
            m_result = (s == 2'b00) ? model8() : model16();
            exp_ov = 1'b1; exp_err = m_pend; m_pend = 1'b0;
         end else if (s == 2'b10 && !c) begin
            exp_err = m_pend; m_pend = 1'b1;
            m_s0 = model_beat(); m_neg = (sa[3] != sb[3]);
         end else if (s == 2'b10) begin
            if (m_pend) begin
               tot = m_s0 + model_beat() * 65536;
               m_result = m_neg ? (64'd0 - tot) : tot;
               exp_ov = 1'b1; m_pend = 1'b0;
            end else begin
               exp_err = 1'b1;
            end
         end else begin
            exp_err = m_pend; m_pend = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      check_value("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
      check_value("acc_pending", {63'd0, acc_pending}, {63'd0, m_pend});
      check_value("result", result, m_result);
`ifdef SEQ_ERR_EN
      check_value("seq_err", {63'd0, seq_err}, {63'd0, exp_err});
`endif
   endtask

   task automatic clear_ops();
      for (int i = 0; i < 8; i++) p[i] = 16'd0;
      sa = 4'd0; sb = 4'd0;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < 8; i++) p[i] = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0) clear_ops();
      sa = 4'($urandom); sb = 4'($urandom);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_value({tag, "_result"}, result, 64'd0);
      check_value({tag, "_ov"}, {63'd0, out_valid}, 64'd0);
      check_value({tag, "_pend"}, {63'd0, acc_pending}, 64'd0);
`ifdef SEQ_ERR_EN
      check_value({tag, "_err"}, {63'd0, seq_err}, 64'd0);
`endif
   endtask

   initial begin
      int r;
      bit c;
      logic [1:0] s;
      clear_ops();
      #2 reset = 1'b0;
      #1 check_reset_outputs("rst");
      @(posedge clk);
      @(negedge clk) reset = 1'b1;

      // 8b negation
      p[0] = 16'd15; sa = 4'b0001;
      step(1'b1, 2'b00, 1'b0);
      check_value("t8_const", result, 64'h0000_0000_0000_FFF1);
      // 16b negation
      clear_ops(); p[0] = 16'd6; sa = 4'b0010;
      step(1'b1, 2'b01, 1'b0);
      check_value("t16_const", result, 64'h0000_0000_FFFF_FFFA);
      // 32b two beats, separated by an idle cycle
      clear_ops();
      step(1'b1, 2'b10, 1'b0);
      step(1'b0, 2'b00, 1'b0);
      p[1] = 16'd1;
      step(1'b1, 2'b10, 1'b1);
      check_value("t32_const", result, 64'h0000_0000_0100_0000);
      // Two first beats then a second beat
      rand_ops(); step(1'b1, 2'b10, 1'b0);
      rand_ops(); step(1'b1, 2'b10, 1'b0);
      rand_ops(); step(1'b1, 2'b10, 1'b1);
      // Orphan second beat, then violation by an 8b beat in ACC
      rand_ops(); step(1'b1, 2'b10, 1'b1);
      rand_ops(); step(1'b1, 2'b10, 1'b0);
      rand_ops(); step(1'b1, 2'b00, 1'b0);
      rand_ops(); step(1'b1, 2'b10, 1'b0);
      rand_ops(); step(1'b1, 2'b11, 1'b0);

      // Reset mid-accumulation
      rand_ops(); step(1'b1, 2'b10, 1'b0);
      in_valid = 1'b0;
      #2 reset = 1'b0;
      #1 check_reset_outputs("midrst");
      m_pend = 1'b0; m_result = 64'd0;
      @(posedge clk);
      @(negedge clk) reset = 1'b1;
      rand_ops(); step(1'b1, 2'b10, 1'b1);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         rand_ops();
         r = $urandom_range(0, 9);
         s = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         c = m_pend;
         if ($urandom_range(0, 6) == 0) c = !c;
         step($urandom_range(0, 9) != 0, s, c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vmul_result_assembler.md
# vmul_result_assembler

Downstream stage of the 8-lane 8x8 unsigned multiplier array in the vector multiply unit. It takes the eight 16-bit unsigned partial products, the operand sign bits and the element width, and produces one registered 64-bit widening signed result. For 32-bit elements it accumulates two consecutive beats before applying the sign.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  partial-product beat present this cycle
- sew  in  2  element width: 00=8b, 01=16b, 10=32b, 11=reserved
- count_0  in  1  32-bit beat index: 0=first beat (B0/B1), 1=second beat (B2/B3)
- p1 … p8  in  16 each  unsigned partial products from multiplier lanes 1..8
- sign_A0 … sign_A3, sign_B0 … sign_B3  in  1 each  MSB of operand byte 0..3
- result  out  64  widening signed product(s)
- out_valid  out  1  one-cycle pulse when result updates
- acc_pending  out  1  first 32-bit beat captured, second beat awaited
- seq_err  out  1  one-cycle pulse on a beat-protocol violation (only with SEQ_ERR_EN)

## Operation
- Lane mapping, sew=00: p(i+1)=|Ai|·|Bi| for i=0..3; p5..p8 ignored.
- Lane mapping, sew=01: element 0 uses p1=A0B0, p2=A1B0, p3=A0B1, p4=A1B1. Element 1 uses p5=A2B2, p6=A3B2, p7=A2B3, p8=A3B3.
- Lane mapping, sew=10: on beat k (k=count_0), p1..p4=A0..A3·B(2k) and p5..p8=A0..A3·B(2k+1).
- 8b result: result[16i+15:16i] = p(i+1), two's-complement negated when sign_Ai^sign_Bi.
- 16b result, per element: sum = pL0 + (pL1<<8) + (pL2<<8) + (pL3<<16), 32 bits. Negate when the sign bits of the element's top byte differ: element 0 uses A1/B1, element 1 uses A3/B3. Element 0 goes to result[31:0], element 1 to [63:32].
- 32b beat sum: S = Σ p(i+1)<<8i + Σ p(i+5)<<8(i+1), computed at 48 bits.
- 32b result: result = S_beat0 + (S_beat1<<16) at 64 bits, negated when sign_A3^sign_B3. The signs are captured on beat 0.
- All sums are modulo their stated widths. Negating a zero magnitude yields 0.
- FSM IDLE: in_valid with sew 00 or 01 produces a result and stays in IDLE.
- FSM IDLE: in_valid with sew=10 and count_0=0 stores S and the signs, then goes to ACC.
- FSM IDLE: in_valid with sew=10 and count_0=1 is a violation. The beat is dropped and the FSM stays in IDLE.
- FSM IDLE: sew=11 is dropped silently.
- FSM ACC: in_valid with sew=10 and count_0=1 produces the 32b result, then goes to IDLE.
- FSM ACC: in_valid with sew=10 and count_0=0 is a violation. The new beat replaces the stored one and the FSM stays in ACC.
- FSM ACC: in_valid with sew≠10 is a violation. The stored beat is discarded, the new beat is processed exactly as in IDLE, and the FSM goes to IDLE (or stays in ACC only if the new beat is a valid 32b first beat).
- FSM ACC: no in_valid means hold.
- acc_pending = (state==ACC).
- No backpressure. result holds its last value until the next out_valid.

## Timing
- Reset values: result=0, out_valid=0, acc_pending=0, seq_err=0, state=IDLE. Any stored beat is cleared.
- 8b/16b latency: result and out_valid appear one cycle after the in_valid edge.
- 32b latency: out_valid appears one cycle after the second beat. Beats may be back-to-back or separated by idle cycles.
- A beat accepted in the same cycle that finishes a 32b result may start the next operation. Full throughput is one 8b/16b result per cycle, or one 32b result per two cycles.
- seq_err pulses in the cycle after the violating beat.
- Reset asserted mid-accumulation forces IDLE immediately. A beat 1 arriving after reset release is a violation.

## Configuration
- SEQ_ERR_EN defined: seq_err port and violation detection are present.
- SEQ_ERR_EN undefined: the seq_err port is absent. The FSM recovery behaviour is identical, with no flag.

## Test plan
- 8b negation: sew=00, p1=15, sign_A0=1, sign_B0=0, other p=0, signs 0 → result[15:0]=0xFFF1, other halves 0, out_valid pulse one cycle later.
- 16b negation: sew=01, p1=6, sign_A1=1, sign_B1=0 → result[31:0]=0xFFFFFFFA, result[63:32]=0.
- 32b two-beat, beat 0: sew=10, count_0=0, all p=0 → acc_pending=1 next cycle, out_valid=0.
- 32b two-beat, beat 1: sew=10, count_0=1, p2=1, others 0, signs 0 → result=0x0000000001000000 (256·65536), out_valid one cycle after beat 1, acc_pending=0.
- Protocol violation: two count_0=0 beats in a row, then count_0=1 → seq_err pulse after the second beat, and the result uses the second beat's S only. A count_0=1 beat in IDLE → seq_err pulse, no out_valid.
- Reset mid-operation: assert reset while acc_pending=1 → all outputs 0 immediately. After release, a count_0=1 beat gives seq_err=1 and out_valid=0.
